// File: rtl/wishbone_controller_mux.sv
// Four-controller Wishbone front end sharing one device port.
// One transaction in flight; the grant comes from an external arbiter.
module wishbone_controller_mux #(
    parameter int ADDR_WIDTH     = 24,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              ctrl_cyc,
    input  logic [3:0]              ctrl_stb,
    input  logic [3:0]              ctrl_we,
    input  logic [15:0]             ctrl_sel,
    input  logic [4*ADDR_WIDTH-1:0] ctrl_adr,
    input  logic [127:0]            ctrl_dat_w,
    output logic [3:0]              ctrl_ack,
    output logic [3:0]              ctrl_err,
    output logic [31:0]             ctrl_dat_r,
    output logic [3:0]              request,
    input  logic [1:0]              controllerSelected,
    output logic                    dev_cyc,
    output logic                    dev_stb,
    output logic                    dev_we,
    output logic [3:0]              dev_sel,
    output logic [ADDR_WIDTH-1:0]   dev_adr,
    output logic [31:0]             dev_dat_w,
    input  logic                    dev_ack,
    input  logic                    dev_err,
    input  logic [31:0]             dev_dat_r,
    output logic [7:0]              timeout_count
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    localparam logic [9:0] TLIM = 10'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_n;
    logic [1:0] owner;
    logic [9:0] timer;
    logic       err_q;
    logic       accept;
    logic       capture;
    logic       tmo;
    logic       tick;

    assign request = ctrl_cyc;
    assign dev_cyc = (state == BUSY);
    assign dev_stb = (state == BUSY);

    always_comb begin
        ctrl_ack = 4'b0000;
        ctrl_err = 4'b0000;
        if (state == RESPOND) begin
            if (err_q)
                ctrl_err = 4'b0001 << owner;
            else
                ctrl_ack = 4'b0001 << owner;
        end
    end

    // Abort beats a device response, which beats the timeout.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        tick    = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl_cyc[controllerSelected] &&
                    ctrl_stb[controllerSelected]) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!ctrl_cyc[owner]) begin
                    state_n = IDLE;
                end else if (dev_ack || dev_err) begin
                    capture = 1'b1;
                    state_n = RESPOND;
                end else if (timer == TLIM) begin
                    tmo     = 1'b1;
                    state_n = RESPOND;
                end else begin
                    tick = 1'b1;
                end
            end
            RESPOND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= 2'd0;
            timer         <= 10'd0;
            err_q         <= 1'b0;
            ctrl_dat_r    <= 32'd0;
            dev_we        <= 1'b0;
            dev_sel       <= 4'd0;
            dev_adr       <= '0;
            dev_dat_w     <= 32'd0;
            timeout_count <= 8'd0;
        end else begin
            state <= state_n;
            if (accept) begin
                owner     <= controllerSelected;
                dev_we    <= ctrl_we[controllerSelected];
                dev_sel   <= ctrl_sel[4*controllerSelected +: 4];
                dev_adr   <= ctrl_adr[ADDR_WIDTH*controllerSelected +: ADDR_WIDTH];
                dev_dat_w <= ctrl_dat_w[32*controllerSelected +: 32];
                timer     <= 10'd0;
            end
            if (tick)
                timer <= timer + 10'd1;
            if (capture) begin
                ctrl_dat_r <= dev_dat_r;
                err_q      <= dev_err;
            end
            if (tmo) begin
                err_q <= 1'b1;
                if (timeout_count != 8'hFF)
                    timeout_count <= timeout_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_wishbone_controller_mux.sv
// Scoreboard bench for wishbone_controller_mux.
// Inputs change at negedge+1; responses are checked at negedge.
module tb_wishbone_controller_mux;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    ctrl_cyc, ctrl_stb, ctrl_we;
    logic [15:0]   ctrl_sel;
    logic [4*AW-1:0] ctrl_adr;
    logic [127:0]  ctrl_dat_w;
    logic [3:0]    ctrl_ack, ctrl_err;
    logic [31:0]   ctrl_dat_r;
    logic [3:0]    request;
    logic [1:0]    controllerSelected;
    logic          dev_cyc, dev_stb, dev_we;
    logic [3:0]    dev_sel;
    logic [AW-1:0] dev_adr;
    logic [31:0]   dev_dat_w;
    logic          dev_ack, dev_err;
    logic [31:0]   dev_dat_r;
    logic [7:0]    timeout_count;

    wishbone_controller_mux #(
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ctrl_cyc(ctrl_cyc), .ctrl_stb(ctrl_stb), .ctrl_we(ctrl_we),
        .ctrl_sel(ctrl_sel), .ctrl_adr(ctrl_adr), .ctrl_dat_w(ctrl_dat_w),
        .ctrl_ack(ctrl_ack), .ctrl_err(ctrl_err), .ctrl_dat_r(ctrl_dat_r),
        .request(request), .controllerSelected(controllerSelected),
        .dev_cyc(dev_cyc), .dev_stb(dev_stb), .dev_we(dev_we),
        .dev_sel(dev_sel), .dev_adr(dev_adr), .dev_dat_w(dev_dat_w),
        .dev_ack(dev_ack), .dev_err(dev_err), .dev_dat_r(dev_dat_r),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          err;
        bit          chk;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_cnt = 0;
    int   stb_total = 0;
    int   dcnt = 0;
    int   dev_mode = 0;
    int   dev_delay = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Device model: mode 0 ack, 1 err, 2 both, 3 silent.
    always @(negedge clk) begin
        dev_ack = 1'b0;
        dev_err = 1'b0;
        if (dev_stb) begin
            stb_total++;
            if (dcnt == dev_delay) begin
                dev_ack = (dev_mode == 0) || (dev_mode == 2);
                dev_err = (dev_mode == 1) || (dev_mode == 2);
            end
            dcnt++;
        end else begin
            dcnt = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if ((ctrl_ack | ctrl_err) != 4'b0000) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {28'd0, ctrl_ack | ctrl_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_vec", {28'd0, ctrl_ack},
                      e.err ? 32'd0 : (32'd1 << e.idx));
                check("err_vec", {28'd0, ctrl_err},
                      e.err ? (32'd1 << e.idx) : 32'd0);
                if (e.chk)
                    check("dat_r", ctrl_dat_r, e.dat);
            end
            resp_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic we, input logic [3:0] sel,
                         input logic [AW-1:0] adr, input logic [31:0] dat);
        ctrl_cyc[i] = 1'b1;
        ctrl_stb[i] = 1'b1;
        ctrl_we[i]  = we;
        ctrl_sel[4*i +: 4]    = sel;
        ctrl_adr[AW*i +: AW]  = adr;
        ctrl_dat_w[32*i +: 32] = dat;
        controllerSelected = 2'(i);
    endtask

    task automatic release_ctrl(input int i);
        ctrl_cyc[i] = 1'b0;
        ctrl_stb[i] = 1'b0;
    endtask

    task automatic push(input int i, input bit err, input bit chk,
                        input logic [31:0] dat);
        exp_t e;
        e.idx = i;
        e.err = err;
        e.chk = chk;
        e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic wait_stb(input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (dev_stb) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_stb", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_resp(input int budget);
        int  start = resp_cnt;
        bit  ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (resp_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_resp", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;
        int rc;
        rst = 1'b1;
        ctrl_cyc = 4'b1010;
        ctrl_stb = 4'b0000;
        ctrl_we = 4'b0000;
        ctrl_sel = 16'd0;
        ctrl_adr = '0;
        ctrl_dat_w = 128'd0;
        controllerSelected = 2'd0;
        dev_dat_r = 32'd0;
        step();
        step();
        check("rst_request", {28'd0, request}, 32'h0000000A);
        check("rst_dev_cyc", {31'd0, dev_cyc}, 32'd0);
        check("rst_ack_err", {24'd0, ctrl_ack, ctrl_err}, 32'd0);
        check("rst_dat_r", ctrl_dat_r, 32'd0);
        check("rst_tmo_cnt", {24'd0, timeout_count}, 32'd0);
        ctrl_cyc = 4'b0000;
        rst = 1'b0;
        step();

        // Controller 2 read, ack two cycles after strobe
        dev_mode = 0;
        dev_delay = 2;
        dev_dat_r = 32'hDEADBEEF;
        base = stb_total;
        issue(2, 1'b0, 4'hF, 24'h001000, 32'd0);
        push(2, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_stb(5);
        check("rd_dev_adr", {8'd0, dev_adr}, 32'h00001000);
        check("rd_dev_we", {31'd0, dev_we}, 32'd0);
        check("rd_dev_cyc", {31'd0, dev_cyc}, 32'd1);
        wait_resp(10);
        check("rd_stb_cycles", stb_total - base, 32'd3);
        release_ctrl(2);
        step();
        check("rd_ack_one_cycle", {28'd0, ctrl_ack}, 32'd0);
        check("rd_dat_hold", ctrl_dat_r, 32'hDEADBEEF);

        // Controller 0 write, device silent, timeout after 4 cycles
        dev_mode = 3;
        base = stb_total;
        issue(0, 1'b1, 4'b0011, 24'h000ABC, 32'h12345678);
        push(0, 1'b1, 1'b1, 32'hDEADBEEF);
        wait_stb(5);
        check("wr_dev_we", {31'd0, dev_we}, 32'd1);
        check("wr_dev_sel", {28'd0, dev_sel}, 32'h3);
        check("wr_dev_dat", dev_dat_w, 32'h12345678);
        wait_resp(12);
        check("tmo_stb_cycles", stb_total - base, 32'd4);
        check("tmo_count", {24'd0, timeout_count}, 32'd1);
        release_ctrl(0);
        step();

        // Controllers 1 and 3 contend, grant goes to 3 first
        dev_mode = 0;
        dev_delay = 0;
        dev_dat_r = 32'h0BADF00D;
        base = stb_total;
        issue(1, 1'b0, 4'hF, 24'h111111, 32'd0);
        issue(3, 1'b0, 4'hF, 24'h333333, 32'd0);
        push(3, 1'b0, 1'b1, 32'h0BADF00D);
        wait_stb(5);
        check("arb_first_adr", {8'd0, dev_adr}, 32'h00333333);
        wait_resp(10);
        check("arb_min_stb", stb_total - base, 32'd1);
        check("arb_no_overlap", {31'd0, dev_cyc}, 32'd0);
        release_ctrl(3);
        controllerSelected = 2'd1;
        dev_dat_r = 32'h600DCAFE;
        push(1, 1'b0, 1'b1, 32'h600DCAFE);
        wait_stb(5);
        check("arb_second_adr", {8'd0, dev_adr}, 32'h00111111);
        wait_resp(10);
        release_ctrl(1);
        step();

        // ack and err together: error wins
        dev_mode = 2;
        dev_delay = 1;
        dev_dat_r = 32'hCAFE0004;
        issue(3, 1'b1, 4'hC, 24'h00F000, 32'hA5A5A5A5);
        push(3, 1'b1, 1'b1, 32'hCAFE0004);
        wait_resp(10);
        release_ctrl(3);
        step();

        // Abort in the same cycle as dev_ack
        dev_mode = 0;
        dev_delay = 1;
        rc = resp_cnt;
        issue(1, 1'b0, 4'hF, 24'h000200, 32'd0);
        wait_stb(5);
        step();
        release_ctrl(1);
        step();
        check("abort_dev_cyc", {31'd0, dev_cyc}, 32'd0);
        check("abort_ack_err", {24'd0, ctrl_ack, ctrl_err}, 32'd0);
        repeat (3) step();
        check("abort_no_resp", resp_cnt - rc, 32'd0);

        // Reset while BUSY
        dev_mode = 3;
        rc = resp_cnt;
        issue(2, 1'b1, 4'h5, 24'hABCDEF, 32'h55AA55AA);
        wait_stb(5);
        rst = 1'b1;
        step();
        check("rstb_dev_cyc", {30'd0, dev_cyc, dev_stb}, 32'd0);
        check("rstb_payload", dev_dat_w | {8'd0, dev_adr} |
              {28'd0, dev_sel} | {31'd0, dev_we}, 32'd0);
        check("rstb_dat_r", ctrl_dat_r, 32'd0);
        check("rstb_tmo_cnt", {24'd0, timeout_count}, 32'd0);
        check("rstb_request", {28'd0, request}, 32'h4);
        release_ctrl(2);
        rst = 1'b0;
        repeat (3) step();
        check("rstb_no_resp", resp_cnt - rc, 32'd0);

        // Saturate timeout_count
        for (int n = 0; n < 257; n++) begin
            issue(0, 1'b0, 4'hF, 24'h000010, 32'd0);
            push(0, 1'b1, 1'b1, 32'd0);
            wait_resp(12);
            release_ctrl(0);
            step();
            if (n == 253)
                check("tmo_count_254", {24'd0, timeout_count}, 32'd254);
        end
        check("tmo_count_sat", {24'd0, timeout_count}, 32'd255);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
